hd44780_lcd_responder: RTL and testbench

HD44780_LCD_RESPONDER -- requirements
Module: hd44780_lcd_responder

---
 rtl/hd44780_lcd_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_hd44780_lcd_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd44780_lcd_responder.sv
// Behavioural HD44780 bus responder: 80-byte DDRAM, address counter, display control and clear-fill FSM.
// Define LCD_BUSY_EN to add the execution-time busy timer (BUSY_US / CLEAR_US).
module hd44780_lcd_responder #(
    parameter int unsigned CNT1US   = 100,
    parameter int unsigned BUSY_US  = 40,
    parameter int unsigned CLEAR_US = 1640
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_dout,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char,
    output logic       wr_pulse,
    output logic       cmd_err
);

    typedef enum logic [0:0] {StIdle, StFill} state_t;

    // Map a valid DDRAM address (line 1: 0x00-0x27, line 2: 0x40-0x67) to a storage index 0..79.
    function automatic logic [6:0] addr2idx(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    logic [10:0] sync1_q, sync2_q;
    logic        e_prev_q;
    logic        txn_q, txn_rs_q, txn_rw_q;
    logic [7:0]  txn_data_q;
    logic        e_fall;

    state_t      state_q, state_d;
    logic [6:0]  fill_idx_q, fill_idx_d;
    logic [6:0]  ac_q, ac_d;
    logic        disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d, inc_q, inc_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_pulse_q, wr_pulse_d, cmd_err_q, cmd_err_d;
    logic [7:0]  dbg_q;
    logic        busy_w;

    logic [7:0]  ram [80];
    logic        ram_we;
    logic [6:0]  ram_widx;
    logic [7:0]  ram_wdata;

`ifdef LCD_BUSY_EN
    localparam logic [31:0] BusyCycles  = 32'(BUSY_US * CNT1US);
    localparam logic [31:0] ClearCycles = 32'(CLEAR_US * CNT1US);
    logic [31:0] timer_q, timer_d;
    assign busy_w = (state_q == StFill) || (timer_q != 32'd0);
`else
    assign busy_w = (state_q == StFill);
`endif

    // Second synchronizer stage is the one edge detection looks at.
    assign e_fall = e_prev_q & ~sync2_q[10];

    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        ac_d       = ac_q;
        disp_d     = disp_q;
        cursor_d   = cursor_q;
        blink_d    = blink_q;
        inc_d      = inc_q;
        dout_d     = dout_q;
        wr_pulse_d = 1'b0;
        cmd_err_d  = 1'b0;
        ram_we     = 1'b0;
        ram_widx   = addr2idx(ac_q);
        ram_wdata  = txn_data_q;
`ifdef LCD_BUSY_EN
        timer_d    = (timer_q != 32'd0) ? timer_q - 32'd1 : 32'd0;
`endif

        unique case (state_q)
            StFill: begin
                ram_we    = 1'b1;
                ram_widx  = fill_idx_q;
                ram_wdata = 8'h20;
                if (fill_idx_q == 7'd79) begin
                    state_d    = StIdle;
                    fill_idx_d = 7'd0;
                end else begin
                    fill_idx_d = fill_idx_q + 7'd1;
                end
            end
            default: ;
        endcase

        // A transaction colliding with FILL is dropped because busy covers the whole fill.
        if (txn_q) begin
            if (busy_w) begin
                cmd_err_d = 1'b1;
            end else begin
`ifdef LCD_BUSY_EN
                timer_d = BusyCycles;
`endif
                if (!txn_rs_q && !txn_rw_q) begin
                    if (txn_data_q[7]) begin
                        if (txn_data_q[5:0] >= 6'h28) cmd_err_d = 1'b1;
                        else                          ac_d      = txn_data_q[6:0];
                    end else if (txn_data_q[6] || txn_data_q[5] || txn_data_q[4]) begin
                        // CGRAM address, function set and shift have no visible effect here.
                    end else if (txn_data_q[3]) begin
                        disp_d   = txn_data_q[2];
                        cursor_d = txn_data_q[1];
                        blink_d  = txn_data_q[0];
                    end else if (txn_data_q[2]) begin
                        inc_d = txn_data_q[1];
                    end else if (txn_data_q[1]) begin
                        ac_d = 7'd0;
`ifdef LCD_BUSY_EN
                        timer_d = ClearCycles;
`endif
                    end else if (txn_data_q[0]) begin
                        state_d    = StFill;
                        fill_idx_d = 7'd0;
                        ac_d       = 7'd0;
                        inc_d      = 1'b1;
`ifdef LCD_BUSY_EN
                        timer_d = ClearCycles;
`endif
                    end
                end else if (!txn_rs_q && txn_rw_q) begin
                    dout_d = {busy_w, ac_q};
                end else if (txn_rs_q && !txn_rw_q) begin
                    ram_we     = 1'b1;
                    wr_pulse_d = 1'b1;
                    ac_d       = step_ac(ac_q, inc_q);
                end else begin
                    dout_d = ram[addr2idx(ac_q)];
                    ac_d   = step_ac(ac_q, inc_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            e_prev_q   <= 1'b0;
            txn_q      <= 1'b0;
            txn_rs_q   <= 1'b0;
            txn_rw_q   <= 1'b0;
            txn_data_q <= 8'h00;
            state_q    <= StIdle;
            fill_idx_q <= 7'd0;
            ac_q       <= 7'd0;
            disp_q     <= 1'b0;
            cursor_q   <= 1'b0;
            blink_q    <= 1'b0;
            inc_q      <= 1'b1;
            dout_q     <= 8'h00;
            wr_pulse_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            dbg_q      <= 8'h00;
`ifdef LCD_BUSY_EN
            timer_q    <= 32'd0;
`endif
        end else begin
            sync1_q    <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
            sync2_q    <= sync1_q;
            e_prev_q   <= sync2_q[10];
            txn_q      <= e_fall;
            txn_rs_q   <= sync2_q[9];
            txn_rw_q   <= sync2_q[8];
            txn_data_q <= sync2_q[7:0];
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            ac_q       <= ac_d;
            disp_q     <= disp_d;
            cursor_q   <= cursor_d;
            blink_q    <= blink_d;
            inc_q      <= inc_d;
            dout_q     <= dout_d;
            wr_pulse_q <= wr_pulse_d;
            cmd_err_q  <= cmd_err_d;
            dbg_q      <= (dbg_addr[5:0] < 6'h28) ? ram[addr2idx(dbg_addr)] : 8'h00;
`ifdef LCD_BUSY_EN
            timer_q    <= timer_d;
`endif
        end
    end

    // DDRAM is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_widx] <= ram_wdata;
    end

    assign lcd_dout  = dout_q;
    assign busy      = busy_w;
    assign ac        = ac_q;
    assign disp_on   = disp_q;
    assign cursor_on = cursor_q;
    assign blink_on  = blink_q;
    assign entry_inc = inc_q;
    assign dbg_char  = dbg_q;
    assign wr_pulse  = wr_pulse_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed bench for hd44780_lcd_responder; run with +define+LCD_BUSY_EN to also exercise the busy timer.
module tb_hd44780_lcd_responder;

    localparam int GAP = 50;

    logic       clk = 1'b0;
    logic       resetn;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [7:0] lcd_dout;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_inc;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] dbg_char;
    logic       wr_pulse, cmd_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    hd44780_lcd_responder #(
        .CNT1US  (1),
        .BUSY_US (40),
        .CLEAR_US(1640)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data),
        .lcd_dout (lcd_dout),
        .busy     (busy),
        .ac       (ac),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .entry_inc(entry_inc),
        .dbg_addr (dbg_addr),
        .dbg_char (dbg_char),
        .wr_pulse (wr_pulse),
        .cmd_err  (cmd_err)
    );

    always @(posedge clk) begin
        if (wr_pulse) wr_cnt <= wr_cnt + 1;
        if (cmd_err)  err_cnt <= err_cnt + 1;
    end

    // Returns on the negedge where lcd_e drops.
    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    task automatic op(input logic rs, input logic rw, input logic [7:0] d, input int gap);
        xfer(rs, rw, d);
        repeat (gap) @(negedge clk);
    endtask

    task automatic dbg_read(input logic [6:0] a, output logic [7:0] v);
        @(negedge clk);
        dbg_addr = a;
        repeat (2) @(posedge clk);
        #1 v = dbg_char;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ac, disp_on, cursor_on, blink_on, entry_inc} !== {1'b0, 7'h00, 4'b0001}) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {busy, ac, disp_on, cursor_on, blink_on, entry_inc}, {1'b0, 7'h00, 4'b0001});
        end
        checks++;
        if ({lcd_dout, dbg_char, wr_pulse, cmd_err} !== 18'h0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", {lcd_dout, dbg_char, wr_pulse, cmd_err});
        end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_init;
        logic [7:0] seq [6];
        logic [7:0] v;
        seq = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h02};
        for (int i = 0; i < 6; i++) op(1'b0, 1'b0, seq[i], 4000);
        checks++;
        if ({disp_on, cursor_on, blink_on, entry_inc, ac} !== {4'b1001, 7'h00}) begin
            errors++;
            $display("FAIL init_state: got %b expected %b",
                     {disp_on, cursor_on, blink_on, entry_inc, ac}, {4'b1001, 7'h00});
        end
        for (int i = 0; i < 80; i++) begin
            logic [6:0] a;
            a = (i < 40) ? 7'(i) : 7'(i + 24);
            dbg_read(a, v);
            checks++;
            if (v !== 8'h20) begin
                errors++;
                $display("FAIL init_fill[%h]: got %h expected 20", a, v);
            end
        end
    endtask

    task automatic test_writes;
        logic [7:0] v;
        logic [7:0] dat [4];
        int w0;
        dat = '{8'h32, 8'h30, 8'h32, 8'h34};
        w0 = wr_cnt;
        op(1'b0, 1'b0, 8'h80, GAP);
        // Latency: effect lands on the 4th posedge after lcd_e drops (edges E0..E3).
        xfer(1'b1, 1'b0, dat[0]);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ac !== 7'h00) begin
            errors++;
            $display("FAIL latency_early: ac got %h expected 00", ac);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ac !== 7'h01) begin
            errors++;
            $display("FAIL latency_edge: ac got %h expected 01", ac);
        end
        repeat (GAP) @(negedge clk);
        for (int i = 1; i < 4; i++) op(1'b1, 1'b0, dat[i], GAP);
        for (int i = 0; i < 4; i++) begin
            dbg_read(7'(i), v);
            checks++;
            if (v !== dat[i]) begin
                errors++;
                $display("FAIL write_data[%0d]: got %h expected %h", i, v, dat[i]);
            end
        end
        checks++;
        if (ac !== 7'h04 || wr_cnt - w0 !== 4) begin
            errors++;
            $display("FAIL write_ac_pulses: ac %h pulses %0d expected ac 04 pulses 4", ac, wr_cnt - w0);
        end
    endtask

    task automatic test_wrap_inc;
        logic [7:0] v;
        int e0;
        op(1'b0, 1'b0, 8'hA7, GAP);
        op(1'b1, 1'b0, 8'h41, GAP);
        op(1'b1, 1'b0, 8'h42, GAP);
        dbg_read(7'h27, v);
        checks++;
        if (v !== 8'h41) begin errors++; $display("FAIL wrap_27: got %h expected 41", v); end
        dbg_read(7'h40, v);
        checks++;
        if (v !== 8'h42) begin errors++; $display("FAIL wrap_40: got %h expected 42", v); end
        checks++;
        if (ac !== 7'h41) begin errors++; $display("FAIL wrap_ac: got %h expected 41", ac); end
        e0 = err_cnt;
        op(1'b0, 1'b0, 8'hA8, GAP);
        checks++;
        if (ac !== 7'h41 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL bad_addr_28: ac %h errs %0d expected ac 41 errs 1", ac, err_cnt - e0);
        end
        op(1'b1, 1'b0, 8'h55, GAP);
        checks++;
        if (ac !== 7'h42) begin errors++; $display("FAIL write_41_ac: got %h expected 42", ac); end
    endtask

    task automatic test_decrement;
        logic [7:0] v;
        int e0;
        op(1'b0, 1'b0, 8'h04, GAP);
        op(1'b0, 1'b0, 8'h80, GAP);
        op(1'b1, 1'b0, 8'h66, GAP);
        checks++;
        if (ac !== 7'h67 || entry_inc !== 1'b0) begin
            errors++;
            $display("FAIL dec_wrap_00: ac %h inc %b expected ac 67 inc 0", ac, entry_inc);
        end
        op(1'b0, 1'b0, 8'hC0, GAP);
        op(1'b1, 1'b0, 8'h43, GAP);
        checks++;
        if (ac !== 7'h27) begin errors++; $display("FAIL dec_wrap_40: got %h expected 27", ac); end
        dbg_read(7'h40, v);
        checks++;
        if (v !== 8'h43) begin errors++; $display("FAIL dec_data_40: got %h expected 43", v); end
        e0 = err_cnt;
        op(1'b0, 1'b0, 8'hFF, GAP);
        checks++;
        if (ac !== 7'h27 || err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL bad_addr_ff: ac %h errs %0d expected ac 27 errs 1", ac, err_cnt - e0);
        end
        op(1'b0, 1'b1, 8'h00, GAP);
        checks++;
        if (lcd_dout !== 8'h27) begin errors++; $display("FAIL ir_read: got %h expected 27", lcd_dout); end
        op(1'b0, 1'b0, 8'h06, GAP);
    endtask

`ifdef LCD_BUSY_EN
    task automatic test_busy;
        logic [7:0] v;
        int e0;
        op(1'b0, 1'b0, 8'h90, GAP);
        op(1'b1, 1'b0, 8'h61, 8);
        e0 = err_cnt;
        op(1'b1, 1'b0, 8'h62, 46);
        checks++;
        if (err_cnt - e0 !== 1 || ac !== 7'h11) begin
            errors++;
            $display("FAIL busy_drop: errs %0d ac %h expected errs 1 ac 11", err_cnt - e0, ac);
        end
        dbg_read(7'h11, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL busy_drop_ram: got %h expected 20", v); end
        op(1'b1, 1'b0, 8'h63, GAP);
        dbg_read(7'h11, v);
        checks++;
        if (v !== 8'h63 || ac !== 7'h12) begin
            errors++;
            $display("FAIL busy_accept: data %h ac %h expected 63 12", v, ac);
        end
    endtask
`endif

    task automatic test_clear_reset;
        logic [7:0] v;
        bit seen;
        seen = 1'b0;
        xfer(1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1 seen = busy;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL clear_busy: got 0 expected 1"); end
        // Fill indices 0..39 complete on the next 40 edges; reset lands before index 40.
        repeat (40) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (GAP) @(negedge clk);
        checks++;
        if ({busy, entry_inc, disp_on} !== 3'b010) begin
            errors++;
            $display("FAIL abort_state: got %b expected 010", {busy, entry_inc, disp_on});
        end
        op(1'b0, 1'b1, 8'h00, GAP);
        checks++;
        if (lcd_dout !== 8'h00) begin errors++; $display("FAIL abort_ir_read: got %h expected 00", lcd_dout); end
        for (int i = 0; i < 40; i++) begin
            dbg_read(7'(i), v);
            checks++;
            if (v !== 8'h20) begin errors++; $display("FAIL abort_filled[%0d]: got %h expected 20", i, v); end
        end
        dbg_read(7'h40, v);
        checks++;
        if (v !== 8'h43) begin errors++; $display("FAIL abort_kept_40: got %h expected 43", v); end
        dbg_read(7'h41, v);
        checks++;
        if (v !== 8'h55) begin errors++; $display("FAIL abort_kept_41: got %h expected 55", v); end
    endtask

    task automatic test_data_read;
        op(1'b1, 1'b1, 8'h00, GAP);
        checks++;
        if (lcd_dout !== 8'h20 || ac !== 7'h01) begin
            errors++;
            $display("FAIL dr_read0: dout %h ac %h expected 20 01", lcd_dout, ac);
        end
        op(1'b0, 1'b0, 8'hC1, GAP);
        op(1'b1, 1'b1, 8'h00, GAP);
        checks++;
        if (lcd_dout !== 8'h55 || ac !== 7'h42) begin
            errors++;
            $display("FAIL dr_read41: dout %h ac %h expected 55 42", lcd_dout, ac);
        end
        op(1'b0, 1'b0, 8'h0F, GAP);
        checks++;
        if (lcd_dout !== 8'h55 || {disp_on, cursor_on, blink_on} !== 3'b111) begin
            errors++;
            $display("FAIL dout_hold: dout %h dcb %b expected 55 111", lcd_dout,
                     {disp_on, cursor_on, blink_on});
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_writes();
        test_wrap_inc();
        test_decrement();
`ifdef LCD_BUSY_EN
        test_busy();
`endif
        test_clear_reset();
        test_data_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
